// File: rtl/tick_debouncer_pkg.sv
// Shared types for the tick-sampled button debouncer.
package tick_debouncer_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchronizer for an asynchronous input, followed by a one-cycle
// rising-edge detector on the synchronized value.
module sync_rise_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~prev;

endmodule

// File: rtl/tick_debouncer.sv
// Debounces btn_raw using sample ticks derived from rising edges of tick_src.
// Define DEBOUNCER_REPEAT_EN to add the btn_repeat auto-repeat strobe.
module tick_debouncer
    import tick_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_TICKS = 16,
    parameter int REPEAT_TICKS = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_src,
    input  logic btn_raw,
`ifdef DEBOUNCER_REPEAT_EN
    output logic btn_repeat,
`endif
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int              CNT_W    = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic tick;
    logic sample;
    logic btn_rise_unused;

    sync_rise_detect #(.STAGES(SYNC_STAGES)) u_tick_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (tick_src),
        .sync (),
        .rise (tick)
    );

    sync_rise_detect #(.STAGES(SYNC_STAGES)) u_btn_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_raw),
        .sync (sample),
        .rise (btn_rise_unused)
    );

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             level_next, press_next, release_next;

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        level_next   = btn_level;
        press_next   = 1'b0;
        release_next = 1'b0;
        if (tick) begin
            unique case (state)
                STABLE_LO: if (sample) begin
                    if (STABLE_TICKS == 1) begin
                        state_next = STABLE_HI;
                        level_next = 1'b1;
                        press_next = 1'b1;
                    end else begin
                        state_next = CHK_HI;
                        cnt_next   = CNT_ONE;
                    end
                end
                CHK_HI: if (sample) begin
                    if (cnt == CNT_LAST) begin
                        state_next = STABLE_HI;
                        level_next = 1'b1;
                        press_next = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end else begin
                    state_next = STABLE_LO;
                    cnt_next   = '0;
                end
                STABLE_HI: if (!sample) begin
                    if (STABLE_TICKS == 1) begin
                        state_next   = STABLE_LO;
                        level_next   = 1'b0;
                        release_next = 1'b1;
                    end else begin
                        state_next = CHK_LO;
                        cnt_next   = CNT_ONE;
                    end
                end
                CHK_LO: if (!sample) begin
                    if (cnt == CNT_LAST) begin
                        state_next   = STABLE_LO;
                        level_next   = 1'b0;
                        release_next = 1'b1;
                        cnt_next     = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end else begin
                    state_next = STABLE_HI;
                    cnt_next   = '0;
                end
                default: begin
                    state_next = STABLE_LO;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= STABLE_LO;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            btn_level   <= level_next;
            btn_press   <= press_next;
            btn_release <= release_next;
        end
    end

`ifdef DEBOUNCER_REPEAT_EN
    localparam int              REP_W    = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);

    logic [REP_W-1:0] rep_cnt, rep_next;
    logic             repeat_next;

    // Held time restarts at each accepted press and is discarded once the
    // button is back in STABLE_LO; glitches in CHK_LO keep it running.
    always_comb begin
        rep_next    = rep_cnt;
        repeat_next = 1'b0;
        if (press_next || state_next == STABLE_LO) begin
            rep_next = '0;
        end else if (tick && (state == STABLE_HI || state == CHK_LO)) begin
            if (rep_cnt == REP_LAST) begin
                repeat_next = 1'b1;
                rep_next    = '0;
            end else begin
                rep_next = rep_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt    <= '0;
            btn_repeat <= 1'b0;
        end else begin
            rep_cnt    <= rep_next;
            btn_repeat <= repeat_next;
        end
    end
`endif

endmodule

// File: tb/tb_tick_debouncer.sv
// Scoreboard bench for tick_debouncer: expected strobes are queued with the
// tick_src rising-edge index at which they must appear; a monitor pops them.
module tb_tick_debouncer;
    import tick_debouncer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic tick_src;
    logic btn_raw;
    logic btn_level, btn_press, btn_release;
`ifdef DEBOUNCER_REPEAT_EN
    logic btn_repeat;
`endif

    always #5 clk = ~clk;

    tick_debouncer #(
        .SYNC_STAGES  (2),
        .STABLE_TICKS (4),
        .REPEAT_TICKS (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_src    (tick_src),
        .btn_raw     (btn_raw),
`ifdef DEBOUNCER_REPEAT_EN
        .btn_repeat  (btn_repeat),
`endif
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_REPEAT = 2} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       tick;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  fails  = 0;
    int  rise_count = 0;
    bit  tick_run = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic expect_ev(input ev_kind_t kind, input int tick);
        ev_t e;
        e.kind = kind;
        e.tick = tick;
        exp_q.push_back(e);
    endtask

    // tick_src: toggles every 5 clk while running, one rising edge per 10 clk.
    initial begin
        int div = 0;
        tick_src = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_run) begin
                div++;
                if (div == 5) begin
                    div = 0;
                    tick_src = ~tick_src;
                    if (tick_src) rise_count++;
                end
            end
        end
    end

    task automatic handle(input ev_kind_t kind);
        ev_t e;
        check("strobe was expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("strobe kind", int'(kind), int'(e.kind));
            check("strobe tick index", rise_count, e.tick);
            check("level with strobe", int'(btn_level), (e.kind == EV_RELEASE) ? 0 : 1);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (btn_press)   handle(EV_PRESS);
            if (btn_release) handle(EV_RELEASE);
`ifdef DEBOUNCER_REPEAT_EN
            if (btn_repeat)  handle(EV_REPEAT);
`endif
        end
    end

    task automatic wait_rise(input int target);
        int n = 0;
        while (rise_count < target && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (rise_count < target) check("tick source progress", rise_count, target);
    endtask

    // Advance n tick_src rising edges, then settle mid-period.
    task automatic after_ticks(input int n);
        wait_rise(rise_count + n);
        repeat (4) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int p;
        int r;

        // Reset with the raw input high.
        rst = 1'b1;
        btn_raw = 1'b1;
        tick_run = 1'b1;
        repeat (20) @(negedge clk);
        check("reset btn_level", int'(btn_level), 0);
        check("reset btn_press", int'(btn_press), 0);
        check("reset btn_release", int'(btn_release), 0);
        check("reset state", int'(dut.state), int'(STABLE_LO));
        btn_raw = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Clean press.
        after_ticks(2);
        c = rise_count;
        btn_raw = 1'b1;
        expect_ev(EV_PRESS, c + 4);
        after_ticks(6);
        drain("clean press drained");
        check("level after press", int'(btn_level), 1);

        // Clean release.
        c = rise_count;
        btn_raw = 1'b0;
        expect_ev(EV_RELEASE, c + 4);
        after_ticks(6);
        drain("release drained");
        check("level after release", int'(btn_level), 0);

        // Frozen tick source: input activity must not move anything.
        tick_run = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            btn_raw = ~btn_raw;
        end
        btn_raw = 1'b0;
        repeat (10) @(negedge clk);
        check("level while frozen", int'(btn_level), 0);
        check("state while frozen", int'(dut.state), int'(STABLE_LO));
        tick_run = 1'b1;

        // Bounce for 6 ticks, then hold high.
        after_ticks(1);
        for (int i = 0; i < 6; i++) begin
            btn_raw = (i % 2 == 0);
            after_ticks(1);
        end
        check("level after bounce", int'(btn_level), 0);
        btn_raw = 1'b1;
        c = rise_count;
        p = c + 4;
        expect_ev(EV_PRESS, p);
`ifdef DEBOUNCER_REPEAT_EN
        expect_ev(EV_REPEAT, p + 8);
        expect_ev(EV_REPEAT, p + 16);
        expect_ev(EV_REPEAT, p + 24);
`endif
        // Hold 26 ticks past acceptance, then release (accepted at p+30).
        wait_rise(p + 26);
        repeat (4) @(negedge clk);
        check("level while held", int'(btn_level), 1);
        btn_raw = 1'b0;
        expect_ev(EV_RELEASE, p + 30);
        after_ticks(6);
        drain("hold and release drained");
        check("level after hold release", int'(btn_level), 0);

        // Reset in the middle of a CHK_HI run.
        after_ticks(1);
        c = rise_count;
        btn_raw = 1'b1;
        wait_rise(c + 2);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid-check reset state", int'(dut.state), int'(STABLE_LO));
        check("mid-check reset press", int'(btn_press), 0);
        wait_rise(c + 3);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        r = rise_count;
        expect_ev(EV_PRESS, r + 4);
        after_ticks(6);
        drain("press after reset drained");
        check("level after reset press", int'(btn_level), 1);

        repeat (20) @(negedge clk);
        check("scoreboard empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
